// File: rtl/imem_loader.sv
// imem_loader: write-side companion of the instruction memory.
// It takes bytes over a valid/ready handshake and packs every four of them
// into one 32-bit word, with the first byte as the MSB. It then writes the
// words to consecutive addresses starting at 0. While a load is in progress
// it holds the CPU stalled through busy.
// Every output is decoded from the state register or taken from a register,
// so byte_ready never depends combinationally on byte_valid.
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_CNT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_ADDR = ADDR_W'(1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       shift;

    logic count_ok;
    logic start_ok;
    logic start_bad;
    logic xfer;
    logic last_byte;
    logic last_word;

    // Qualify start requests and byte transfers. A zero count is rejected,
    // and so is any count larger than the memory, because either one would
    // make the word index wrap.
    always_comb begin
        count_ok  = (word_count != '0) && (word_count <= DEPTH_W);
        start_ok  = (state == IDLE) && start && count_ok;
        start_bad = (state == IDLE) && start && !count_ok;
        xfer      = (state == RECV) && byte_valid;
        last_byte = xfer && (byte_cnt == 2'd3);
        last_word = ({1'b0, word_idx} == (count_q - ONE_CNT));
    end

    // State register. Reset returns to IDLE at once, and in IDLE every
    // decoded output is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. WRITE and DONE each last exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (last_byte) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_next = DONE;
                end else begin
                    state_next = RECV;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake, stall and memory-port outputs, decoded from state only.
    // Address and data are forced to 0 outside WRITE so the bus stays quiet
    // while no write is in progress.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = word_idx;
                mem_wdata = shift;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                byte_ready = 1'b0;
            end
        endcase
    end

    // Latch the requested word count when a load is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (start_ok) begin
            count_q <= word_count;
        end
    end

    // Word index. It only advances after a non-final write, so it stops at
    // count-1 and can never pass DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx <= '0;
        end else if (start_ok) begin
            word_idx <= '0;
        end else if ((state == WRITE) && !last_word) begin
            word_idx <= word_idx + ONE_ADDR;
        end
    end

    // Byte counter. After the fourth byte it wraps naturally back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
        end else if (start_ok) begin
            byte_cnt <= 2'd0;
        end else if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Assembly shift register. Earlier bytes move toward the MSB, so the
    // first byte of each group ends up in bits 31:24.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else if (xfer) begin
            shift <= {shift[23:0], byte_in};
        end
    end

    // Sticky error flag. A rejected start sets it and the next accepted
    // start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start_ok) begin
            err <= 1'b0;
        end else if (start_bad) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. The bench keeps its own model of the
// instruction memory and a log of every write the loader issues.
module tb_imem_loader;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] wrAddr [$];
    logic [31:0] wrData [$];
    int          busyCycles = 0;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction-memory model and write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_addr] = mem_wdata;
            wrAddr.push_back(32'(mem_addr));
            wrData.push_back(mem_wdata);
        end
        if (rst_n && busy) begin
            busyCycles = busyCycles + 1;
        end
    end

    // Watchdog, so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [ADDR_W:0] count);
        start      = 1'b1;
        word_count = count;
        tick();
        start      = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            checkOutput("ready_timeout", 32'(byte_ready), 32'd1);
        end else begin
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        sendByte(w[31:24], gap);
        sendByte(w[23:16], 0);
        sendByte(w[15:8], gap);
        sendByte(w[7:0], 0);
    endtask

    task automatic waitDone(input int limit);
        int n;
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
        checkOutput("done_seen", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] genWord(input int k);
        logic [9:0] kk;
        kk = k[9:0];
        return {8'hC3, 6'b0, kk[9:8], kk[7:0], ~kk[7:0]};
    endfunction

    logic [31:0] prog [6] = '{32'h00000013, 32'h00A00093, 32'h00108133,
                              32'hFE000EE3, 32'hDEADBEEF, 32'h12345678};

    initial begin
        int base;
        int busyBase;

        rst_n      = 1'b0;
        start      = 1'b0;
        word_count = '0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        // Reset, then idle with a byte offered but no start.
        repeat (2) tick();
        rst_n = 1'b1;
        checkOutput("rst_state", {25'd0, byte_ready, mem_we, busy, done, err, 2'd0}, 32'd0);
        checkOutput("rst_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        byte_in    = 8'hEE;
        byte_valid = 1'b1;
        repeat (4) tick();
        checkOutput("idle_ready", 32'(byte_ready), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_writes", 32'(wrAddr.size()), 32'd0);
        byte_valid = 1'b0;

        // Single word, back to back. From start to done is 7 cycles inclusive.
        base     = wrAddr.size();
        busyBase = busyCycles;
        applyStimulus(11'd1);
        checkOutput("w1_busy_on", 32'(busy), 32'd1);
        checkOutput("w1_ready_on", 32'(byte_ready), 32'd1);
        sendByte(8'h8C, 0);
        sendByte(8'h22, 0);
        sendByte(8'h00, 0);
        sendByte(8'h04, 0);
        checkOutput("w1_we", 32'(mem_we), 32'd1);
        checkOutput("w1_addr", 32'(mem_addr), 32'd0);
        checkOutput("w1_data", mem_wdata, 32'h8C220004);
        checkOutput("w1_ready_wr", 32'(byte_ready), 32'd0);
        tick();
        checkOutput("w1_done", 32'(done), 32'd1);
        checkOutput("w1_busy_done", 32'(busy), 32'd0);
        checkOutput("w1_we_done", 32'(mem_we), 32'd0);
        tick();
        checkOutput("w1_done_pulse", 32'(done), 32'd0);
        // busy covers the four receive cycles plus the write cycle.
        checkOutput("w1_busy_span", 32'(busyCycles - busyBase), 32'd5);
        checkOutput("w1_nwrites", 32'(wrAddr.size() - base), 32'd1);

        // Six words with gaps in byte_valid.
        base = wrAddr.size();
        applyStimulus(11'd6);
        for (int k = 0; k < 6; k++) begin
            sendWord(prog[k], k % 3);
        end
        waitDone(4);
        tick();
        checkOutput("w6_nwrites", 32'(wrAddr.size() - base), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (base + k < wrAddr.size()) begin
                checkOutput($sformatf("w6_addr%0d", k), wrAddr[base + k], 32'(k));
                checkOutput($sformatf("w6_data%0d", k), wrData[base + k], prog[k]);
            end
            checkOutput($sformatf("w6_mem%0d", k), mem[k], prog[k]);
        end

        // Illegal counts set err and leave the loader idle.
        applyStimulus(11'd0);
        checkOutput("bad0_err", 32'(err), 32'd1);
        checkOutput("bad0_busy", 32'(busy), 32'd0);
        applyStimulus(11'd1025);
        checkOutput("bad1025_err", 32'(err), 32'd1);
        checkOutput("bad1025_busy", 32'(busy), 32'd0);
        checkOutput("bad1025_ready", 32'(byte_ready), 32'd0);

        // A legal start clears err. A start pulsed mid-load is ignored.
        base = wrAddr.size();
        applyStimulus(11'd2);
        checkOutput("ok_err_clr", 32'(err), 32'd0);
        checkOutput("ok_busy", 32'(busy), 32'd1);
        sendByte(8'hA1, 0);
        start      = 1'b1;
        word_count = 11'd1;
        sendByte(8'hA2, 0);
        start      = 1'b0;
        sendByte(8'hA3, 0);
        sendByte(8'hA4, 0);
        sendWord(32'hB1B2B3B4, 1);
        waitDone(4);
        tick();
        checkOutput("ovl_nwrites", 32'(wrAddr.size() - base), 32'd2);
        checkOutput("ovl_mem0", mem[0], 32'hA1A2A3A4);
        checkOutput("ovl_mem1", mem[1], 32'hB1B2B3B4);
        checkOutput("ovl_idle", 32'(busy), 32'd0);
        checkOutput("ovl_err", 32'(err), 32'd0);

        // Full-depth load.
        base = wrAddr.size();
        applyStimulus(11'd1024);
        for (int k = 0; k < DEPTH; k++) begin
            sendWord(genWord(k), 0);
        end
        checkOutput("full_last_addr", 32'(mem_addr), 32'd1023);
        checkOutput("full_last_we", 32'(mem_we), 32'd1);
        tick();
        checkOutput("full_done", 32'(done), 32'd1);
        tick();
        checkOutput("full_nwrites", 32'(wrAddr.size() - base), 32'd1024);
        checkOutput("full_mem0", mem[0], genWord(0));
        checkOutput("full_mem512", mem[512], genWord(512));
        checkOutput("full_mem1023", mem[1023], genWord(1023));

        // Reset in the middle of a load.
        base = wrAddr.size();
        applyStimulus(11'd4);
        sendWord(32'h01020304, 0);
        sendWord(32'h05060708, 0);
        sendByte(8'h77, 0);
        sendByte(8'h88, 0);
        checkOutput("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_ready", 32'(byte_ready), 32'd0);
        checkOutput("mid_we", 32'(mem_we), 32'd0);
        checkOutput("mid_flags", {30'd0, done, err}, 32'd0);
        checkOutput("mid_addr", 32'(mem_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        checkOutput("mid_nwrites", 32'(wrAddr.size() - base), 32'd2);
        applyStimulus(11'd1);
        sendWord(32'h11223344, 0);
        checkOutput("re_addr", 32'(mem_addr), 32'd0);
        checkOutput("re_data", mem_wdata, 32'h11223344);
        waitDone(4);
        tick();
        checkOutput("re_nwrites", 32'(wrAddr.size() - base), 32'd3);
        checkOutput("re_mem0", mem[0], 32'h11223344);
        checkOutput("re_mem1", mem[1], 32'h05060708);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
